// File: rtl/hilo_muldiv_ctrl_pkg.sv
// Shared definitions for the EXE-stage multiply/divide controller:
// op one-hot bit positions, controller states and the default data width.
package cpu_defs;

    localparam int unsigned DW = 32;

    localparam int unsigned OP_W     = 6;
    localparam int unsigned OP_DIV   = 0;
    localparam int unsigned OP_DIVU  = 1;
    localparam int unsigned OP_MULT  = 2;
    localparam int unsigned OP_MULTU = 3;
    localparam int unsigned OP_MTHI  = 4;
    localparam int unsigned OP_MTLO  = 5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_DRAIN
    } state_t;

    function automatic logic is_onehot(input logic [OP_W-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_if.sv
// Request, HI/LO readback and divider AXI-stream signals of the mul/div controller.
interface hilo_muldiv_ctrl_if #(
    parameter int unsigned DW = cpu_defs::DW
);
    logic              req_valid;
    logic              req_ready;
    logic [5:0]        req_op;
    logic [DW-1:0]     req_rs;
    logic [DW-1:0]     req_rt;
    logic              flush;
    logic              done;
    logic              busy;
    logic [DW-1:0]     hi_rdata;
    logic [DW-1:0]     lo_rdata;
    logic              div_signed;
    logic              divisor_tvalid;
    logic              divisor_tready;
    logic [DW-1:0]     divisor_tdata;
    logic              dividend_tvalid;
    logic              dividend_tready;
    logic [DW-1:0]     dividend_tdata;
    logic              dout_tvalid;
    logic [2*DW-1:0]   dout_tdata;

    modport slave (
        input  req_valid, req_op, req_rs, req_rt, flush,
               divisor_tready, dividend_tready, dout_tvalid, dout_tdata,
        output req_ready, done, busy, hi_rdata, lo_rdata, div_signed,
               divisor_tvalid, divisor_tdata, dividend_tvalid, dividend_tdata
    );

    modport master (
        output req_valid, req_op, req_rs, req_rt, flush,
               divisor_tready, dividend_tready, dout_tvalid, dout_tdata,
        input  req_ready, done, busy, hi_rdata, lo_rdata, div_signed,
               divisor_tvalid, divisor_tdata, dividend_tvalid, dividend_tdata
    );

endinterface

// File: rtl/hilo_muldiv_ctrl_axis_sender.sv
// One divider input channel: raises tvalid on start, holds it until the
// handshake, and remembers that the beat has been sent.
module hilo_axis_sender (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic tready,
    output logic tvalid,
    output logic complete
);

    logic sent;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tvalid <= 1'b0;
            sent   <= 1'b0;
        end else if (start) begin
            tvalid <= 1'b1;
            sent   <= 1'b0;
        end else if (tvalid && tready) begin
            tvalid <= 1'b0;
            sent   <= 1'b1;
        end
    end

    // True once the beat is delivered, including the handshake cycle itself.
    assign complete = sent || (tvalid && tready);

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// EXE-stage multiply/divide sequencer owning HI/LO; multiplies inline,
// divides through a two-channel AXI-stream divider IP.
module hilo_muldiv_ctrl #(
    parameter int unsigned DW = cpu_defs::DW
) (
    input logic               clk,
    input logic               reset,
    hilo_muldiv_ctrl_if.slave bus
);
    import cpu_defs::*;

    state_t          state, state_next;
    logic [DW-1:0]   hi, lo;
    logic [DW-1:0]   dividend_q, divisor_q;
    logic            done_q, div_signed_q, kill_q;
    logic            accept, start_div, mul_signed;
    logic            wr_mul, wr_mthi, wr_mtlo, wr_div;
    logic            divisor_tvalid, dividend_tvalid;
    logic            divisor_complete, dividend_complete;
    logic [2*DW-1:0] ext_rs, ext_rt, product;

    assign accept    = bus.req_valid && (state == S_IDLE) && !bus.flush
                       && is_onehot(bus.req_op);
    assign start_div = accept && (bus.req_op[OP_DIV] || bus.req_op[OP_DIVU]);

    assign mul_signed = bus.req_op[OP_MULT];
    assign ext_rs     = {{DW{mul_signed & bus.req_rs[DW-1]}}, bus.req_rs};
    assign ext_rt     = {{DW{mul_signed & bus.req_rt[DW-1]}}, bus.req_rt};
    assign product    = ext_rs * ext_rt;

    hilo_axis_sender u_divisor (
        .clk      (clk),
        .reset    (reset),
        .start    (start_div),
        .tready   (bus.divisor_tready),
        .tvalid   (divisor_tvalid),
        .complete (divisor_complete)
    );

    hilo_axis_sender u_dividend (
        .clk      (clk),
        .reset    (reset),
        .start    (start_div),
        .tready   (bus.dividend_tready),
        .tvalid   (dividend_tvalid),
        .complete (dividend_complete)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        wr_mul     = 1'b0;
        wr_mthi    = 1'b0;
        wr_mtlo    = 1'b0;
        wr_div     = 1'b0;
        unique case (state)
            S_IDLE: begin
                wr_mul  = accept && (bus.req_op[OP_MULT] || bus.req_op[OP_MULTU]);
                wr_mthi = accept && bus.req_op[OP_MTHI];
                wr_mtlo = accept && bus.req_op[OP_MTLO];
                if (start_div) state_next = S_SEND;
            end
            S_SEND: begin
                // A flush here must not strand a half-sent operand pair in the IP.
                if (divisor_complete && dividend_complete)
                    state_next = (kill_q || bus.flush) ? S_DRAIN : S_WAIT;
            end
            S_WAIT: begin
                if (bus.flush) begin
                    state_next = S_DRAIN;
                end else if (bus.dout_tvalid) begin
                    wr_div     = 1'b1;
                    state_next = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (bus.dout_tvalid) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi           <= '0;
            lo           <= '0;
            done_q       <= 1'b0;
            kill_q       <= 1'b0;
            div_signed_q <= 1'b0;
            dividend_q   <= '0;
            divisor_q    <= '0;
        end else begin
            done_q <= wr_mul || wr_mthi || wr_mtlo || wr_div;
            kill_q <= (state == S_SEND) && (state_next == S_SEND) && (kill_q || bus.flush);
            if (wr_mul) {hi, lo} <= product;
            if (wr_mthi) hi <= bus.req_rs;
            if (wr_mtlo) lo <= bus.req_rs;
            if (wr_div) begin
                lo <= bus.dout_tdata[2*DW-1:DW];
                hi <= bus.dout_tdata[DW-1:0];
            end
            if (start_div) begin
                dividend_q   <= bus.req_rs;
                divisor_q    <= bus.req_rt;
                div_signed_q <= bus.req_op[OP_DIV];
            end
        end
    end

    assign bus.req_ready       = (state == S_IDLE);
    assign bus.done            = done_q;
    assign bus.busy            = (state != S_IDLE) || done_q;
    assign bus.hi_rdata        = hi;
    assign bus.lo_rdata        = lo;
    assign bus.div_signed      = div_signed_q;
    assign bus.divisor_tvalid  = divisor_tvalid;
    assign bus.divisor_tdata   = divisor_q;
    assign bus.dividend_tvalid = dividend_tvalid;
    assign bus.dividend_tdata  = dividend_q;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed bench for hilo_muldiv_ctrl with hand-computed HI/LO and handshake expectations.
module tb_hilo_muldiv_ctrl;

    logic clk = 1'b0;
    logic reset;

    int vectors     = 0;
    int miscompares = 0;

    int cyc           = 0;
    int done_cnt      = 0;
    int dvd_hs        = 0;
    int dvs_hs        = 0;
    int last_done_cyc = 0;
    int prev_done_cyc = 0;
    int base_done, base_dvd, base_dvs;

    always #5 clk = ~clk;

    hilo_muldiv_ctrl_if #(.DW(32)) bus ();

    hilo_muldiv_ctrl #(.DW(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (bus.done) begin
            done_cnt      = done_cnt + 1;
            prev_done_cyc = last_done_cyc;
            last_done_cyc = cyc;
        end
        if (bus.dividend_tvalid && bus.dividend_tready) dvd_hs = dvd_hs + 1;
        if (bus.divisor_tvalid && bus.divisor_tready)   dvs_hs = dvs_hs + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] rs, input logic [31:0] rt);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_rs    = rs;
        bus.req_rt    = rt;
    endtask

    initial begin
        reset               = 1'b1;
        bus.req_valid       = 1'b0;
        bus.req_op          = '0;
        bus.req_rs          = '0;
        bus.req_rt          = '0;
        bus.flush           = 1'b0;
        bus.divisor_tready  = 1'b0;
        bus.dividend_tready = 1'b0;
        bus.dout_tvalid     = 1'b0;
        bus.dout_tdata      = '0;

        tick(); tick();
        chk("rst_hilo", {bus.hi_rdata, bus.lo_rdata}, 64'h0);
        chk("rst_flags", {bus.done, bus.busy, bus.divisor_tvalid, bus.dividend_tvalid, bus.div_signed}, 5'b0);
        chk("rst_tdata", {bus.divisor_tdata, bus.dividend_tdata}, 64'h0);
        reset = 1'b0;
        tick();
        chk("rst_ready", bus.req_ready, 1);

        // MULT -2 * 3
        issue(6'b000100, 32'hFFFF_FFFE, 32'd3);
        tick();
        bus.req_valid = 1'b0;
        chk("mult_done", bus.done, 1);
        chk("mult_hilo", {bus.hi_rdata, bus.lo_rdata}, 64'hFFFF_FFFF_FFFF_FFFA);
        chk("mult_busy", bus.busy, 1);
        tick();
        chk("mult_done_clr", bus.done, 0);

        // MULTU 0xFFFFFFFE * 3
        issue(6'b001000, 32'hFFFF_FFFE, 32'd3);
        tick();
        bus.req_valid = 1'b0;
        chk("multu_done", bus.done, 1);
        chk("multu_hilo", {bus.hi_rdata, bus.lo_rdata}, 64'h0000_0002_FFFF_FFFA);
        tick();

        // non-one-hot op: no effect
        issue(6'b000011, 32'h1111_1111, 32'h2222_2222);
        tick();
        bus.req_valid = 1'b0;
        chk("badop_flags", {bus.done, bus.req_ready, bus.divisor_tvalid, bus.dividend_tvalid}, 4'b0100);
        chk("badop_hilo", {bus.hi_rdata, bus.lo_rdata}, 64'h0000_0002_FFFF_FFFA);

        // DIV -7 / 2, IP answers q=-3 r=-1
        base_done = done_cnt; base_dvd = dvd_hs; base_dvs = dvs_hs;
        bus.divisor_tready  = 1'b1;
        bus.dividend_tready = 1'b1;
        issue(6'b000001, 32'hFFFF_FFF9, 32'd2);
        tick();
        bus.req_valid = 1'b0;
        chk("div_send_valid", {bus.divisor_tvalid, bus.dividend_tvalid}, 2'b11);
        chk("div_send_data", {bus.dividend_tdata, bus.divisor_tdata}, 64'hFFFF_FFF9_0000_0002);
        chk("div_send_flags", {bus.div_signed, bus.req_ready, bus.busy}, 3'b101);
        tick();
        chk("div_wait_valid", {bus.divisor_tvalid, bus.dividend_tvalid}, 2'b00);
        for (int i = 0; i < 18; i++) begin
            tick();
            chk("div_wait_flags", {bus.req_ready, bus.div_signed, bus.done}, 3'b010);
        end
        bus.dout_tvalid = 1'b1;
        bus.dout_tdata  = 64'hFFFF_FFFD_FFFF_FFFF;
        tick();
        bus.dout_tvalid = 1'b0;
        chk("div_done", {bus.done, bus.req_ready}, 2'b11);
        chk("div_hilo", {bus.hi_rdata, bus.lo_rdata}, 64'hFFFF_FFFF_FFFF_FFFD);
        tick(); tick();
        chk("div_done_once", done_cnt - base_done, 1);
        chk("div_hs_once", {dvd_hs - base_dvd, dvs_hs - base_dvs}, {32'd1, 32'd1});

        // DIVU 50 / 7 with divisor ready lagging dividend by 3 cycles
        base_dvd = dvd_hs; base_dvs = dvs_hs;
        bus.divisor_tready  = 1'b0;
        bus.dividend_tready = 1'b1;
        issue(6'b000010, 32'd50, 32'd7);
        tick();
        bus.req_valid = 1'b0;
        chk("divu_send", {bus.divisor_tvalid, bus.dividend_tvalid, bus.div_signed}, 3'b110);
        tick();
        chk("divu_dvd_drop", {bus.divisor_tvalid, bus.dividend_tvalid}, 2'b10);
        tick(); tick();
        chk("divu_dvs_hold", {bus.divisor_tvalid, bus.dividend_tvalid, bus.req_ready}, 3'b100);
        bus.divisor_tready = 1'b1;
        tick();
        chk("divu_dvs_drop", bus.divisor_tvalid, 0);
        tick(); tick();
        chk("divu_hs_once", {dvd_hs - base_dvd, dvs_hs - base_dvs}, {32'd1, 32'd1});
        bus.dout_tvalid = 1'b1;
        bus.dout_tdata  = {32'd7, 32'd1};
        tick();
        bus.dout_tvalid = 1'b0;
        chk("divu_done", bus.done, 1);
        chk("divu_hilo", {bus.hi_rdata, bus.lo_rdata}, {32'd1, 32'd7});
        tick();

        // DIVU 100 / 7 flushed in WAIT; result discarded
        base_done = done_cnt;
        issue(6'b000010, 32'd100, 32'd7);
        tick();
        bus.req_valid = 1'b0;
        tick(); tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("flush_drain", {bus.busy, bus.req_ready}, 2'b10);
        bus.dout_tvalid = 1'b1;
        bus.dout_tdata  = {32'd14, 32'd2};
        tick();
        bus.dout_tvalid = 1'b0;
        chk("flush_nodone", {bus.done, bus.req_ready}, 2'b01);
        chk("flush_hilo", {bus.hi_rdata, bus.lo_rdata}, {32'd1, 32'd7});
        issue(6'b010000, 32'h0000_1234, 32'd0);
        tick();
        bus.req_valid = 1'b0;
        chk("mthi_after_flush", {bus.hi_rdata, bus.lo_rdata}, {32'h1234, 32'd7});
        tick();
        chk("flush_done_count", done_cnt - base_done, 1);

        // flush together with dout in WAIT: result dropped, DRAIN waits for next result
        issue(6'b000010, 32'd9, 32'd4);
        tick();
        bus.req_valid = 1'b0;
        tick(); tick();
        bus.flush       = 1'b1;
        bus.dout_tvalid = 1'b1;
        bus.dout_tdata  = {32'd2, 32'd1};
        tick();
        bus.flush       = 1'b0;
        bus.dout_tvalid = 1'b0;
        chk("flushdout_state", {bus.done, bus.req_ready}, 2'b00);
        chk("flushdout_hilo", {bus.hi_rdata, bus.lo_rdata}, {32'h1234, 32'd7});
        bus.dout_tvalid = 1'b1;
        tick();
        bus.dout_tvalid = 1'b0;
        chk("flushdout_idle", {bus.done, bus.req_ready}, 2'b01);

        // flush in the cycle an MTLO is requested
        bus.flush = 1'b1;
        issue(6'b100000, 32'h55, 32'd0);
        tick();
        bus.req_valid = 1'b0;
        bus.flush     = 1'b0;
        chk("flush_mtlo", {bus.done, bus.req_ready}, 2'b01);
        chk("flush_mtlo_lo", bus.lo_rdata, 32'd7);
        tick();

        // reset asserted while stuck in SEND
        bus.divisor_tready  = 1'b0;
        bus.dividend_tready = 1'b0;
        issue(6'b000001, 32'd9, 32'd3);
        tick();
        bus.req_valid = 1'b0;
        chk("rstsend_valid", {bus.divisor_tvalid, bus.dividend_tvalid}, 2'b11);
        #2 reset = 1'b1;
        #1;
        chk("rstsend_async", {bus.divisor_tvalid, bus.dividend_tvalid, bus.busy, bus.div_signed}, 4'b0);
        chk("rstsend_hilo", {bus.hi_rdata, bus.lo_rdata}, 64'h0);
        #3 reset = 1'b0;
        tick();
        chk("rstsend_ready", bus.req_ready, 1);
        bus.dout_tvalid = 1'b1;
        bus.dout_tdata  = 64'hAAAA_AAAA_BBBB_BBBB;
        tick();
        bus.dout_tvalid = 1'b0;
        chk("stray_dout", {bus.done, bus.busy, bus.req_ready}, 3'b001);
        chk("stray_hilo", {bus.hi_rdata, bus.lo_rdata}, 64'h0);
        bus.divisor_tready  = 1'b1;
        bus.dividend_tready = 1'b1;

        // MTHI then MTLO, each issued once the previous done is seen
        issue(6'b010000, 32'hA, 32'd0);
        tick();
        bus.req_valid = 1'b0;
        chk("mthi_done", {bus.done, bus.hi_rdata}, {1'b1, 32'hA});
        tick();
        chk("mthi_done_clr", bus.done, 0);
        issue(6'b100000, 32'hB, 32'd0);
        tick();
        bus.req_valid = 1'b0;
        chk("mtlo_done", bus.done, 1);
        chk("mthilo_vals", {bus.hi_rdata, bus.lo_rdata}, {32'hA, 32'hB});
        tick();
        chk("done_spacing", last_done_cyc - prev_done_cyc, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
